// File: rtl/lb_uart_pkg.sv
// Shared types for the local-bus UART transmit path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package lb_uart_pkg;

    // Drain FSM states; busy is any state other than IDLE.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Bit positions inside the processor-visible status byte.
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;

    // Assemble the status byte; upper nibble is reserved and reads as zero.
    function automatic logic [7:0] pack_status(input logic busy, input logic ovf,
                                               input logic full, input logic empty);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_BUSY]  = busy;
        s[ST_OVF]   = ovf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/lb_uart_tx_fifo_if.sv
// Processor-port and UART-side signal bundle for the transmit FIFO.
// Latency: none, wiring only.
// Backpressure: uart_txrdy paces the drain; a full FIFO drops pushes.
interface lb_uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              clr_ovf;
    logic              tx_enable;
    logic [7:0]        status;
    logic [ADDR_W:0]   level;
    logic [7:0]        uart_data;
    logic              uart_we;
    logic              uart_cs_n;
    logic              uart_txrdy;

    // Environment side: processor strobes plus the UART ready flag.
    modport master (
        output wr_en, wr_data, clr_ovf, tx_enable, uart_txrdy,
        input  status, level, uart_data, uart_we, uart_cs_n
    );

    // FIFO block side.
    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_enable, uart_txrdy,
        output status, level, uart_data, uart_we, uart_cs_n
    );
endinterface

// File: rtl/lb_sync_fifo.sv
// Single-clock byte FIFO, register-array store, first-word-fall-through dout.
// Latency: push visible at dout the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module lb_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lb_uart_tx_fifo.sv
// Queues processor bytes and drains them one frame at a time into the UART.
// Latency: push into idle/empty path gives uart_we one edge later, high for one cycle.
// Backpressure: waits on uart_txrdy low-then-high per frame; full FIFO drops and sets ovf.
module lb_uart_tx_fifo
    import lb_uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lb_uart_tx_fifo_if.slave     bus
);

    state_t            state_q;
    state_t            state_d;
    logic              we_q;
    logic              we_d;
    logic              cs_n_q;
    logic              cs_n_d;
    logic [7:0]        data_q;
    logic [7:0]        data_d;
    logic              ovf_q;
    logic              pop;
    logic              drop;
    logic [7:0]        fifo_dout;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    lb_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (bus.wr_en),
        .pop    (pop),
        .din    (bus.wr_data),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A push is lost only when full and nothing leaves in the same cycle.
    assign drop = bus.wr_en && fifo_full && !pop;

    // Next-state and next-output logic; the UART strobe is launched only from IDLE.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        cs_n_d  = 1'b1;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && bus.tx_enable && bus.uart_txrdy) begin
                    pop     = 1'b1;
                    we_d    = 1'b1;
                    cs_n_d  = 1'b0;
                    data_d  = fifo_dout;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.uart_txrdy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.uart_txrdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered UART outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            cs_n_q  <= cs_n_d;
            data_q  <= data_d;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.uart_we   = we_q;
    assign bus.uart_cs_n = cs_n_q;
    assign bus.uart_data = data_q;
    assign bus.level     = fifo_count;
    assign bus.status    = pack_status(state_q != IDLE, ovf_q, fifo_full, fifo_empty);

endmodule
